// File: rtl/div_nbits_seq.sv
// rtl/div_nbits_seq.sv - multi-cycle unsigned restoring divider sharing one sub_nbits subtractor
// Optional divide-by-zero short-circuit is enabled by defining DIV_ZERO_CHK_EN.

module sub_nbits #(
  parameter int width = 9
) (
  input  logic [width-1:0] a_i,
  input  logic [width-1:0] b_i,
  output logic [width-1:0] s_o,
  output logic             cout_o
);

  // The extra top bit of the widened difference is the borrow (set when a < b).
  assign {cout_o, s_o} = {1'b0, a_i} - {1'b0, b_i};

endmodule

module div_nbits_seq #(
  parameter int width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [width-1:0] dividend_i,
  input  logic [width-1:0] divisor_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [width-1:0] quotient_o,
  output logic [width-1:0] remainder_o,
  output logic             err_o
);

  localparam int cnt_w = $clog2(width + 1);

  localparam logic [1:0] st_idle = 2'd0;
  localparam logic [1:0] st_run  = 2'd1;
  localparam logic [1:0] st_done = 2'd2;

  logic [1:0]       state;
  logic [width-1:0] rem_q;
  logic [width-1:0] quo_q;
  logic [width-1:0] div_q;
  logic [cnt_w-1:0] cnt;

  logic [width:0]   diff;
  logic             borrow;
  logic             unused_diff_msb;

  sub_nbits #(
    .width (width + 1)
  ) u_sub (
    .a_i    ({rem_q, quo_q[width-1]}),
    .b_i    ({1'b0, div_q}),
    .s_o    (diff),
    .cout_o (borrow)
  );

  // R < D holds after each step, so a successful trial never needs the top bit.
  assign unused_diff_msb = diff[width];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= st_idle;
      rem_q <= '0;
      quo_q <= '0;
      div_q <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        st_idle: begin
          if (start_i) begin
            rem_q <= '0;
            quo_q <= dividend_i;
            div_q <= divisor_i;
            cnt   <= cnt_w'(width);
            state <= st_run;
`ifdef DIV_ZERO_CHK_EN
            if (divisor_i == '0) begin
              rem_q <= dividend_i;
              quo_q <= '1;
              state <= st_done;
            end
`endif
          end
        end
        st_run: begin
          if (!borrow) begin
            rem_q <= diff[width-1:0];
            quo_q <= {quo_q[width-2:0], 1'b1};
          end else begin
            rem_q <= {rem_q[width-2:0], quo_q[width-1]};
            quo_q <= {quo_q[width-2:0], 1'b0};
          end
          cnt <= cnt - cnt_w'(1);
          if (cnt == cnt_w'(1)) begin
            state <= st_done;
          end
        end
        st_done: begin
          state <= st_idle;
        end
        default: begin
          state <= st_idle;
        end
      endcase
    end
  end

`ifdef DIV_ZERO_CHK_EN
  logic err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (state == st_idle && start_i) begin
      err_q <= (divisor_i == '0);
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign ready_o     = (state == st_idle);
  assign done_o      = (state == st_done);
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: tb/tb_div_nbits_seq.sv
// tb/tb_div_nbits_seq.sv - self-checking bench for div_nbits_seq (width 8 and 16)

module tb_div_nbits_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        s8;
  logic [7:0]  a8, b8, q8, r8;
  logic        rdy8, dn8, er8;
  logic        s16;
  logic [15:0] a16, b16, q16, r16;
  logic        rdy16, dn16, er16;

  int n_cmp = 0;
  int n_bad = 0;

  div_nbits_seq #(.width(8)) u_dut8 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(s8), .dividend_i(a8), .divisor_i(b8),
    .ready_o(rdy8), .done_o(dn8), .quotient_o(q8), .remainder_o(r8), .err_o(er8)
  );

  div_nbits_seq #(.width(16)) u_dut16 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(s16), .dividend_i(a16), .divisor_i(b16),
    .ready_o(rdy16), .done_o(dn16), .quotient_o(q16), .remainder_o(r16), .err_o(er16)
  );

  typedef struct {
    logic [7:0] dvd;
    logic [7:0] dvs;
    logic [7:0] q;
    logic [7:0] r;
    logic       err;
    int         lat;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_ready8();
    int guard;
    guard = 0;
    @(negedge clk);
    while (!rdy8 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("ready8_timeout", 32'(rdy8), 32'd1);
  endtask

  task automatic wait_ready16();
    int guard;
    guard = 0;
    @(negedge clk);
    while (!rdy16 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("ready16_timeout", 32'(rdy16), 32'd1);
  endtask

  // lat counts edges from the accepting edge (1) up to the one after which done_o is high.
  task automatic run8(input logic [7:0] dvd, input logic [7:0] dvs, output int lat);
    wait_ready8();
    s8 = 1'b1; a8 = dvd; b8 = dvs;
    @(posedge clk); #1;
    s8 = 1'b0;
    lat = 1;
    while (!dn8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run16(input logic [15:0] dvd, input logic [15:0] dvs, output int lat);
    wait_ready16();
    s16 = 1'b1; a16 = dvd; b16 = dvs;
    @(posedge clk); #1;
    s16 = 1'b0;
    lat = 1;
    while (!dn16 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int dt[$];
    int cyc;
    logic [7:0]  ra, rb;
    logic [15:0] wa, wb;

    vecs[0] = '{dvd: 8'd100, dvs: 8'd7,   q: 8'd14,  r: 8'd2,  err: 1'b0, lat: 9};
    vecs[1] = '{dvd: 8'd255, dvs: 8'd1,   q: 8'd255, r: 8'd0,  err: 1'b0, lat: 9};
    vecs[2] = '{dvd: 8'd5,   dvs: 8'd9,   q: 8'd0,   r: 8'd5,  err: 1'b0, lat: 9};
    vecs[3] = '{dvd: 8'd200, dvs: 8'd200, q: 8'd1,   r: 8'd0,  err: 1'b0, lat: 9};
    vecs[4] = '{dvd: 8'd255, dvs: 8'd255, q: 8'd1,   r: 8'd0,  err: 1'b0, lat: 9};
`ifdef DIV_ZERO_CHK_EN
    vecs[5] = '{dvd: 8'd37,  dvs: 8'd0,   q: 8'd255, r: 8'd37, err: 1'b1, lat: 1};
`else
    vecs[5] = '{dvd: 8'd37,  dvs: 8'd0,   q: 8'd255, r: 8'd37, err: 1'b0, lat: 9};
`endif

    rst_n = 1'b0;
    s8 = 1'b0; a8 = '0; b8 = '0;
    s16 = 1'b0; a16 = '0; b16 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready8", 32'(rdy8), 32'd1);
    check("rst_done8", 32'(dn8), 32'd0);
    check("rst_err8", 32'(er8), 32'd0);
    check("rst_quot8", 32'(q8), 32'd0);
    check("rst_rem8", 32'(r8), 32'd0);
    check("rst_ready16", 32'(rdy16), 32'd1);
    check("rst_quot16", 32'(q16), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run8(vecs[i].dvd, vecs[i].dvs, lat);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_quot", i), 32'(q8), 32'(vecs[i].q));
      check($sformatf("vec%0d_rem", i), 32'(r8), 32'(vecs[i].r));
      check($sformatf("vec%0d_err", i), 32'(er8), 32'(vecs[i].err));
      @(posedge clk); #1;
      check($sformatf("vec%0d_done_pulse", i), 32'(dn8), 32'd0);
      check($sformatf("vec%0d_quot_hold", i), 32'(q8), 32'(vecs[i].q));
    end

    // A start pulse during RUN must be dropped.
    wait_ready8();
    s8 = 1'b1; a8 = 8'd100; b8 = 8'd7;
    @(posedge clk); #1;
    s8 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("ignored_ready_low", 32'(rdy8), 32'd0);
    s8 = 1'b1; a8 = 8'd50; b8 = 8'd5;
    @(negedge clk);
    s8 = 1'b0;
    lat = 0;
    while (!dn8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("ignored_done_seen", 32'(dn8), 32'd1);
    check("ignored_quot", 32'(q8), 32'd14);
    check("ignored_rem", 32'(r8), 32'd2);
    @(posedge clk); #1;
    check("ignored_no_second_run", 32'(rdy8), 32'd1);

    // Held start gives back-to-back operations every width+2 cycles.
    wait_ready8();
    s8 = 1'b1; a8 = 8'd100; b8 = 8'd7;
    for (cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk); #1;
      if (dn8) begin
        dt.push_back(cyc);
        check("held_quot", 32'(q8), 32'd14);
      end
    end
    s8 = 1'b0;
    check("held_done_count", 32'(dt.size() >= 3), 32'd1);
    if (dt.size() >= 3) begin
      check("held_period_a", 32'(dt[1] - dt[0]), 32'd10);
      check("held_period_b", 32'(dt[2] - dt[1]), 32'd10);
    end

    // Asynchronous reset in the middle of RUN.
    wait_ready8();
    s8 = 1'b1; a8 = 8'd100; b8 = 8'd7;
    @(posedge clk); #1;
    s8 = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_ready", 32'(rdy8), 32'd1);
    check("midrst_done", 32'(dn8), 32'd0);
    check("midrst_err", 32'(er8), 32'd0);
    check("midrst_quot", 32'(q8), 32'd0);
    check("midrst_rem", 32'(r8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run8(8'd60, 8'd4, lat);
    check("postrst_lat", 32'(lat), 32'd9);
    check("postrst_quot", 32'(q8), 32'd15);
    check("postrst_rem", 32'(r8), 32'd0);

    // Random operands against plain integer division.
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(1, 255));
      run8(ra, rb, lat);
      check($sformatf("rnd8_quot %0d/%0d", ra, rb), 32'(q8), 32'(ra / rb));
      check($sformatf("rnd8_rem %0d/%0d", ra, rb), 32'(r8), 32'(ra % rb));
      check($sformatf("rnd8_identity %0d/%0d", ra, rb), 32'(int'(q8) * int'(rb) + int'(r8)), 32'(ra));
      check($sformatf("rnd8_rem_lt %0d/%0d", ra, rb), 32'(r8 < rb), 32'd1);
    end

    for (int i = 0; i < 1000; i++) begin
      wa = 16'($urandom_range(0, 65535));
      wb = (i % 4 == 0) ? 16'($urandom_range(1, 255)) : 16'($urandom_range(1, 65535));
      run16(wa, wb, lat);
      check($sformatf("rnd16_lat %0d/%0d", wa, wb), 32'(lat), 32'd17);
      check($sformatf("rnd16_quot %0d/%0d", wa, wb), 32'(q16), 32'(wa / wb));
      check($sformatf("rnd16_rem %0d/%0d", wa, wb), 32'(r16), 32'(wa % wb));
      check($sformatf("rnd16_identity %0d/%0d", wa, wb), 32'(int'(q16) * int'(wb) + int'(r16)), 32'(wa));
      check($sformatf("rnd16_err %0d/%0d", wa, wb), 32'(er16), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
